// File: rtl/seven_seg_pkg.sv
// Shared constants, types and the slot-to-anode map for the seven-segment scan path.
package seven_seg_pkg;

   localparam int unsigned NUM_DIGITS = 4;

   localparam logic [3:0] ANODE_OFF  = 4'b1111;
   localparam logic [3:0] ANODE_DIG0 = 4'b1110;
   localparam logic [3:0] ANODE_DIG1 = 4'b1101;
   localparam logic [3:0] ANODE_DIG2 = 4'b1011;
   localparam logic [3:0] ANODE_DIG3 = 4'b0111;

   typedef logic [1:0] digit_idx_t;

   // Active-low one-cold digit select for a scan slot.
   function automatic logic [3:0] slot_to_anode(input digit_idx_t idx);
      logic [3:0] a;
      a = ANODE_OFF;
      unique case (idx)
         2'd0: a = ANODE_DIG0;
         2'd1: a = ANODE_DIG1;
         2'd2: a = ANODE_DIG2;
         2'd3: a = ANODE_DIG3;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/seven_seg_refresh_tick.sv
// Refresh prescaler: counts REFRESH_DIV cycles per digit slot and strobes on terminal count.
module seven_seg_refresh_tick #(
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic clear_i,
   output logic tick_o
);

   localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] CntMax = CNT_W'(REFRESH_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick_o = en_i && !clear_i && (cnt_q == CntMax);

   // Next count: hold at zero while disabled or cleared, otherwise wrap at terminal count.
   always_comb begin
      cnt_d = cnt_q;
      if (!en_i || clear_i) begin
         cnt_d = '0;
      end else if (cnt_q == CntMax) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/seven_seg_scanner.sv
// Digit scanner: rotates the anode select and applies display loads only at frame boundaries.
module seven_seg_scanner
   import seven_seg_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        load,
   input  logic [15:0] y_in,
   input  logic [3:0]  op_in,
   output logic [15:0] y_out,
   output logic [3:0]  op_out,
   output logic [3:0]  anode,
   output logic        digit_tick,
   output logic        load_ack,
   output logic        pending
);

   localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

   if (REFRESH_DIV < 2) begin : g_bad_div
      $error("seven_seg_scanner: REFRESH_DIV must be >= 2");
   end

   digit_idx_t  idx_q, idx_d;
   logic [3:0]  anode_q, anode_d;
   logic        tick_q, tick_d;
   logic [15:0] y_q, y_d;
   logic [3:0]  op_q, op_d;
   logic [19:0] shadow_q, shadow_d;
   logic        pend_q, pend_d;
   logic        upd_q, upd_d;
   logic        ack_q;
   logic        tick;
   logic        wrap;
   logic        scan_idle;

   // Anode is dark exactly when the previous edge saw en=0 (or reset), so the first enabled
   // edge restarts the prescaler from zero instead of counting.
   assign scan_idle = (anode_q == ANODE_OFF);

   seven_seg_refresh_tick #(
      .REFRESH_DIV(REFRESH_DIV)
   ) u_refresh_tick (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (en),
      .clear_i (scan_idle),
      .tick_o  (tick)
   );

   assign wrap = tick && (idx_q == digit_idx_t'(NUM_DIGITS - 1));

   // Next-state for scan position, anode, display registers and load bookkeeping.
   always_comb begin
      idx_d    = idx_q;
      anode_d  = anode_q;
      tick_d   = 1'b0;
      y_d      = y_q;
      op_d     = op_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      upd_d    = 1'b0;
      if (!en) begin
         idx_d   = '0;
         anode_d = ANODE_OFF;
         pend_d  = 1'b0;
         // Display is dark, so loads (new or waiting) apply immediately.
         if (load) begin
            y_d      = y_in;
            op_d     = op_in;
            shadow_d = {y_in, op_in};
            upd_d    = 1'b1;
         end else if (pend_q) begin
            {y_d, op_d} = shadow_q;
            upd_d       = 1'b1;
         end
      end else begin
         if (tick) begin
            idx_d = idx_q + 2'd1;
         end
         tick_d  = tick;
         anode_d = slot_to_anode(idx_d);
         if (load) begin
            shadow_d = {y_in, op_in};
            if (wrap) begin
               y_d    = y_in;
               op_d   = op_in;
               pend_d = 1'b0;
               upd_d  = 1'b1;
            end else begin
               pend_d = 1'b1;
            end
         end else if (wrap && pend_q) begin
            {y_d, op_d} = shadow_q;
            pend_d      = 1'b0;
            upd_d       = 1'b1;
         end
      end
   end

   // State registers; ack trails the display update by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q    <= '0;
         anode_q  <= ANODE_OFF;
         tick_q   <= 1'b0;
         y_q      <= '0;
         op_q     <= '0;
         shadow_q <= '0;
         pend_q   <= 1'b0;
         upd_q    <= 1'b0;
         ack_q    <= 1'b0;
      end else begin
         idx_q    <= idx_d;
         anode_q  <= anode_d;
         tick_q   <= tick_d;
         y_q      <= y_d;
         op_q     <= op_d;
         shadow_q <= shadow_d;
         pend_q   <= pend_d;
         upd_q    <= upd_d;
         ack_q    <= upd_q;
      end
   end

   assign y_out      = y_q;
   assign op_out     = op_q;
   assign anode      = anode_q;
   assign digit_tick = tick_q;
   assign load_ack   = ack_q;
   assign pending    = pend_q;

endmodule
